// File: rtl/wave_pkg.sv
// wave_pkg: shared types and constants for the stage wave sequencer.
//   - wave_state_e : sequencer FSM states
//   - WAVE_*       : wave index encodings (fly, spider, mosquito)
//   - MASK_*       : enemy slots owned by each wave
//   - wave_mask()  : index -> slot mask lookup
package wave_pkg;

    localparam int WAVE_SLOTS = 23;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPAWN  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_GAP    = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_DONE   = 3'd6
    } wave_state_e;

    localparam logic [1:0] WAVE_FLY      = 2'd0;
    localparam logic [1:0] WAVE_SPIDER   = 2'd1;
    localparam logic [1:0] WAVE_MOSQUITO = 2'd2;

    localparam logic [WAVE_SLOTS-1:0] MASK_FLY      = 23'h01FFFF;  // slots 0..16
    localparam logic [WAVE_SLOTS-1:0] MASK_SPIDER   = 23'h1E0000;  // slots 17..20
    localparam logic [WAVE_SLOTS-1:0] MASK_MOSQUITO = 23'h600000;  // slots 21..22

    // Slot mask of one wave; the unused index 3 owns no slots.
    function automatic logic [WAVE_SLOTS-1:0] wave_mask(input logic [1:0] idx);
        logic [WAVE_SLOTS-1:0] m;
        case (idx)
            WAVE_FLY:      m = MASK_FLY;
            WAVE_SPIDER:   m = MASK_SPIDER;
            WAVE_MOSQUITO: m = MASK_MOSQUITO;
            default:       m = {WAVE_SLOTS{1'b0}};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk25 down to a one-cycle tick every TICK_DIV cycles.
//   clk25        in  system clock
//   global_reset in  asynchronous active-high reset
//   clear        in  restart the count at 0 on the next cycle (dominates hold)
//   hold         in  freeze the count and suppress the tick
//   tick         out high during the last cycle of each TICK_DIV period
module tick_prescaler
    import wave_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk25,
    input  logic global_reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST_C = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ZERO_C = CW'(0);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, then hold, then wrap at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = ZERO_C;
        end else if (hold) begin
            cnt_d = cnt_q;
        end else if (cnt_q == LAST_C) begin
            cnt_d = ZERO_C;
        end else begin
            cnt_d = cnt_q + ONE_C;
        end
    end

    // Count register.
    always_ff @(posedge clk25 or posedge global_reset) begin
        if (global_reset) begin
            cnt_q <= ZERO_C;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A held prescaler must not tick, otherwise pause would leak a second.
    assign tick = (cnt_q == LAST_C) && !hold;

endmodule

// File: rtl/wave_sequencer.sv
// wave_sequencer: releases the fly, spider and mosquito waves of one stage.
// A wave is released after the previous one is cleared plus a gap, or after
// it has been active for the timeout. Release is a req/ack handshake with
// the enemy controller followed by a one-cycle group reset pulse.
//   clk25, global_reset           clock, asynchronous active-high reset
//   start                         begin the stage (honoured in IDLE/DONE)
//   pause                         freezes the tick prescaler and seconds
//   enemy_alive[ENEMY_COUNT]      per-slot alive flags
//   spawn_ack                     controller accepts the spawn request
//   spawn_req, spawn_mask         spawn request and slots to set alive
//   reset_fly/spider/mosquito     one-cycle group reset pulses
//   wave_idx                      current wave (0 fly, 1 spider, 2 mosquito)
//   busy, stage_clear             stage in progress / stage finished
// All outputs come straight from flops.
module wave_sequencer
    import wave_pkg::*;
#(
    parameter int ENEMY_COUNT    = 23,
    parameter int TICK_DIV       = 25_000_000,
    parameter int WAVE_TIMEOUT_S = 10,
    parameter int GAP_S          = 2
) (
    input  logic                   clk25,
    input  logic                   global_reset,
    input  logic                   start,
    input  logic                   pause,
    input  logic [ENEMY_COUNT-1:0] enemy_alive,
    input  logic                   spawn_ack,
    output logic                   spawn_req,
    output logic [ENEMY_COUNT-1:0] spawn_mask,
    output logic                   reset_fly,
    output logic                   reset_spider,
    output logic                   reset_mosquito,
    output logic [1:0]             wave_idx,
    output logic                   busy,
    output logic                   stage_clear
);

    localparam logic [7:0]             TIMEOUT_SEC = 8'(WAVE_TIMEOUT_S);
    localparam logic [7:0]             GAP_SEC     = 8'(GAP_S);
    localparam logic [ENEMY_COUNT-1:0] NO_SLOTS    = {ENEMY_COUNT{1'b0}};

    // Wave mask resized to the slot vector width.
    function automatic logic [ENEMY_COUNT-1:0] slot_mask(input logic [1:0] idx);
        return ENEMY_COUNT'(wave_mask(idx));
    endfunction

    wave_state_e            state_q, state_d;
    logic [1:0]             wave_idx_q, wave_idx_d;
    logic                   settle_q, settle_d;
    logic [7:0]             seconds_q, seconds_d;
    logic                   spawn_req_q, spawn_req_d;
    logic [ENEMY_COUNT-1:0] spawn_mask_q, spawn_mask_d;
    logic                   reset_fly_q, reset_fly_d;
    logic                   reset_spider_q, reset_spider_d;
    logic                   reset_mosquito_q, reset_mosquito_d;
    logic                   busy_q, busy_d;
    logic                   stage_clear_q, stage_clear_d;

    logic                   tick_s;
    logic                   cnt_clear_s;
    logic [7:0]             sec_next_s;
    logic                   cleared_s;
    logic                   all_dead_s;
    logic                   timeout_hit_s;
    logic                   gap_hit_s;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk25        (clk25),
        .global_reset (global_reset),
        .clear        (cnt_clear_s),
        .hold         (pause),
        .tick         (tick_s)
    );

    // Deadlines compare against the value the seconds counter is about to
    // take, so the state changes on the edge where the last second elapses
    // and a wave lasts exactly N*TICK_DIV cycles.
    assign sec_next_s    = seconds_q + {7'd0, tick_s};
    assign timeout_hit_s = (sec_next_s == TIMEOUT_SEC);
    assign gap_hit_s     = (sec_next_s == GAP_SEC);
    assign cleared_s     = ((enemy_alive & slot_mask(wave_idx_q)) == NO_SLOTS);
    assign all_dead_s    = (enemy_alive == NO_SLOTS);

    // Seconds counter next value; tick is already suppressed while paused.
    always_comb begin
        if (cnt_clear_s) begin
            seconds_d = 8'd0;
        end else begin
            seconds_d = sec_next_s;
        end
    end

    // FSM next state, wave index, settle counter and group reset pulses.
    always_comb begin
        state_d          = state_q;
        wave_idx_d       = wave_idx_q;
        settle_d         = 1'b0;
        reset_fly_d      = 1'b0;
        reset_spider_d   = 1'b0;
        reset_mosquito_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    wave_idx_d = WAVE_FLY;
                    state_d    = ST_SPAWN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SPAWN: begin
                if (spawn_ack && spawn_req_q) begin
                    state_d = ST_SETTLE;
                    case (wave_idx_q)
                        WAVE_FLY:      reset_fly_d      = 1'b1;
                        WAVE_SPIDER:   reset_spider_d   = 1'b1;
                        WAVE_MOSQUITO: reset_mosquito_d = 1'b1;
                        default:       reset_fly_d      = 1'b0;
                    endcase
                end else begin
                    state_d = ST_SPAWN;
                end
            end
            ST_SETTLE: begin
                // Two cycles so enemy_alive reflects the spawn before ACTIVE.
                if (settle_q) begin
                    state_d = ST_ACTIVE;
                end else begin
                    settle_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // Clearing takes precedence over a simultaneous timeout.
                if (cleared_s) begin
                    if (wave_idx_q != WAVE_MOSQUITO) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (timeout_hit_s) begin
                    if (wave_idx_q != WAVE_MOSQUITO) begin
                        wave_idx_d = wave_idx_q + 2'd1;
                        state_d    = ST_SPAWN;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_GAP: begin
                if (gap_hit_s) begin
                    wave_idx_d = wave_idx_q + 2'd1;
                    state_d    = ST_SPAWN;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_DRAIN: begin
                // Survivors of timed-out waves hold the stage open.
                if (all_dead_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wave_idx_d = WAVE_FLY;
            end
        endcase
    end

    // Registered outputs follow the next state; counters restart on entry
    // to ACTIVE and GAP.
    always_comb begin
        spawn_req_d = (state_d == ST_SPAWN);
        if (spawn_req_d) begin
            spawn_mask_d = slot_mask(wave_idx_d);
        end else begin
            spawn_mask_d = NO_SLOTS;
        end
        busy_d        = (state_d != ST_IDLE) && (state_d != ST_DONE);
        stage_clear_d = (state_d == ST_DONE);
        cnt_clear_s   = ((state_d == ST_ACTIVE) && (state_q != ST_ACTIVE)) ||
                        ((state_d == ST_GAP)    && (state_q != ST_GAP));
    end

    // State, counters and output registers.
    always_ff @(posedge clk25 or posedge global_reset) begin
        if (global_reset) begin
            state_q          <= ST_IDLE;
            wave_idx_q       <= WAVE_FLY;
            settle_q         <= 1'b0;
            seconds_q        <= 8'd0;
            spawn_req_q      <= 1'b0;
            spawn_mask_q     <= NO_SLOTS;
            reset_fly_q      <= 1'b0;
            reset_spider_q   <= 1'b0;
            reset_mosquito_q <= 1'b0;
            busy_q           <= 1'b0;
            stage_clear_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            wave_idx_q       <= wave_idx_d;
            settle_q         <= settle_d;
            seconds_q        <= seconds_d;
            spawn_req_q      <= spawn_req_d;
            spawn_mask_q     <= spawn_mask_d;
            reset_fly_q      <= reset_fly_d;
            reset_spider_q   <= reset_spider_d;
            reset_mosquito_q <= reset_mosquito_d;
            busy_q           <= busy_d;
            stage_clear_q    <= stage_clear_d;
        end
    end

    assign spawn_req      = spawn_req_q;
    assign spawn_mask     = spawn_mask_q;
    assign reset_fly      = reset_fly_q;
    assign reset_spider   = reset_spider_q;
    assign reset_mosquito = reset_mosquito_q;
    assign wave_idx       = wave_idx_q;
    assign busy           = busy_q;
    assign stage_clear    = stage_clear_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer: randomized stage scenarios; the driver predicts every
// spawn, group reset and stage_clear event (cycle and value) from the timing
// rules and queues it, and a monitor compares events as the DUT emits them.
module tb_wave_sequencer;

    localparam int EC      = 23;
    localparam int TD      = 4;
    localparam int TO      = 3;
    localparam int GS      = 1;
    localparam int ACT_LEN = TO * TD;
    localparam int GAP_LEN = GS * TD;

    logic          clk25        = 1'b0;
    logic          global_reset = 1'b1;
    logic          start        = 1'b0;
    logic          pause        = 1'b0;
    logic          spawn_ack    = 1'b0;
    logic [EC-1:0] enemy_alive  = {EC{1'b0}};
    logic          spawn_req;
    logic [EC-1:0] spawn_mask;
    logic          reset_fly, reset_spider, reset_mosquito;
    logic [1:0]    wave_idx;
    logic          busy, stage_clear;

    wave_sequencer #(
        .ENEMY_COUNT    (EC),
        .TICK_DIV       (TD),
        .WAVE_TIMEOUT_S (TO),
        .GAP_S          (GS)
    ) dut (
        .clk25          (clk25),
        .global_reset   (global_reset),
        .start          (start),
        .pause          (pause),
        .enemy_alive    (enemy_alive),
        .spawn_ack      (spawn_ack),
        .spawn_req      (spawn_req),
        .spawn_mask     (spawn_mask),
        .reset_fly      (reset_fly),
        .reset_spider   (reset_spider),
        .reset_mosquito (reset_mosquito),
        .wave_idx       (wave_idx),
        .busy           (busy),
        .stage_clear    (stage_clear)
    );

    always #5 clk25 = ~clk25;

    int cyc = 0;
    always @(posedge clk25) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // kind: 0 spawn (val = mask), 1 group reset (val = one-hot), 2 stage_clear (val = busy)
    typedef struct {int kind; int at; int val; int idx;} ev_t;
    ev_t exp_q[$];

    int wlo[3] = '{0, 17, 21};
    int whi[3] = '{16, 20, 22};

    int p_to[3], p_k[3], p_surv[3], p_p0[3], p_pl[3], p_gp[3], p_ack[3], p_glitch[3];
    int p_drain;

    function automatic logic [EC-1:0] tb_mask(input int w);
        logic [EC-1:0] r;
        r = {EC{1'b0}};
        for (int b = wlo[w]; b <= whi[w]; b++) r[b] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic take(input int kind, input int val, input int idx);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d val 0x%0h at cycle %0d, want none", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.at);
            chk("event_value", val, e.val);
            chk("event_wave", idx, e.idx);
        end
    endtask

    task automatic expect_ev(input int kind, input int at, input int val, input int idx);
        exp_q.push_back('{kind, at, val, idx});
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk25);
            #1;
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk($sformatf("%s_req", nm), int'(spawn_req), 0);
        chk($sformatf("%s_mask", nm), int'(spawn_mask), 0);
        chk($sformatf("%s_resets", nm), int'({reset_mosquito, reset_spider, reset_fly}), 0);
        chk($sformatf("%s_wave", nm), int'(wave_idx), 0);
        chk($sformatf("%s_busy", nm), int'(busy), 0);
        chk($sformatf("%s_clear", nm), int'(stage_clear), 0);
    endtask

    // Monitor: sample half a cycle after the active edge and match events.
    initial begin : monitor
        logic       prev_req;
        logic [2:0] prev_rst;
        logic       prev_clr;
        logic [2:0] rv;
        prev_req = 1'b0;
        prev_rst = 3'b000;
        prev_clr = 1'b0;
        forever begin
            @(negedge clk25);
            if (global_reset) begin
                prev_req = 1'b0;
                prev_rst = 3'b000;
                prev_clr = 1'b0;
            end else begin
                rv = {reset_mosquito, reset_spider, reset_fly};
                if (!spawn_req) chk("mask_without_req", int'(spawn_mask), 0);
                if (spawn_req && !prev_req) begin
                    chk("busy_on_spawn", int'(busy), 1);
                    take(0, int'(spawn_mask), int'(wave_idx));
                end
                if (prev_rst != 3'b000) chk("reset_pulse_width", int'(rv), 0);
                else if (rv != 3'b000) take(1, int'(rv), int'(wave_idx));
                if (stage_clear && !prev_clr) take(2, int'(busy), int'(wave_idx));
                prev_req = spawn_req;
                prev_rst = rv;
                prev_clr = stage_clear;
            end
        end
    end

    // One full stage driven from the p_* plan; expectations derive from it.
    task automatic run_stage();
        int sp, m, a, last, g, d, dn;
        sp = cyc + 1;
        start = 1'b1;
        expect_ev(0, sp, int'(tb_mask(0)), 0);
        goto(sp);
        start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            m = sp + p_ack[w];
            for (int c = sp; c <= m; c++) begin
                goto(c);
                pause     = 1'($urandom_range(0, 1));
                spawn_ack = (c == m);
            end
            expect_ev(1, m + 1, 1 << w, w);
            goto(m + 1);
            spawn_ack   = 1'b0;
            pause       = 1'b0;
            enemy_alive = enemy_alive | tb_mask(w);
            a = m + 3;
            if (p_to[w] != 0) last = a + ACT_LEN - 1 + p_pl[w];
            else last = a + p_k[w];
            for (int c = a; c <= last; c++) begin
                goto(c);
                pause = (c >= a + p_p0[w]) && (c < a + p_p0[w] + p_pl[w]);
                start = (p_glitch[w] != 0) && (c == a + 1);
                if (c == a + p_k[w]) begin
                    if (p_to[w] != 0)
                        enemy_alive = (enemy_alive & ~tb_mask(w)) | (23'd1 << p_surv[w]);
                    else
                        enemy_alive = enemy_alive & ~tb_mask(w);
                end
            end
            goto(last + 1);
            pause = 1'b0;
            start = 1'b0;
            if (w < 2) begin
                if (p_to[w] != 0) begin
                    sp = last + 1;
                end else begin
                    g = last + 1;
                    for (int c = g; c < g + p_gp[w]; c++) begin
                        goto(c);
                        pause = 1'b1;
                    end
                    goto(g + p_gp[w]);
                    pause     = 1'b0;
                    spawn_ack = 1'b1;
                    goto(g + p_gp[w] + 1);
                    spawn_ack = 1'b0;
                    sp = g + GAP_LEN + p_gp[w];
                end
                expect_ev(0, sp, int'(tb_mask(w + 1)), w + 1);
            end else begin
                if (enemy_alive == {EC{1'b0}}) begin
                    dn = last + 2;
                end else begin
                    d = last + 1 + p_drain;
                    goto(d);
                    enemy_alive = {EC{1'b0}};
                    dn = d + 1;
                end
                expect_ev(2, dn, 0, 2);
                goto(dn + int'($urandom_range(0, 2)));
            end
        end
    endtask

    task automatic rand_plan();
        for (int w = 0; w < 3; w++) begin
            p_to[w]     = int'($urandom_range(0, 1));
            p_k[w]      = int'($urandom_range(0, ACT_LEN - 1));
            p_surv[w]   = wlo[w] + int'($urandom_range(0, whi[w] - wlo[w]));
            p_ack[w]    = int'($urandom_range(0, 3));
            p_gp[w]     = int'($urandom_range(0, 3));
            p_glitch[w] = int'($urandom_range(0, 1));
            p_p0[w]     = int'($urandom_range(0, 5));
            p_pl[w]     = int'($urandom_range(0, 8));
            if (p_to[w] == 0) begin
                if (p_p0[w] > p_k[w]) p_pl[w] = 0;
                else if (p_p0[w] + p_pl[w] > p_k[w] + 1) p_pl[w] = p_k[w] + 1 - p_p0[w];
            end
        end
        p_drain = int'($urandom_range(0, 4));
    endtask

    task automatic set_wave(input int w, input int to, input int k, input int surv,
                            input int p0, input int pl, input int ack);
        p_to[w] = to; p_k[w] = k; p_surv[w] = surv; p_p0[w] = p0; p_pl[w] = pl;
        p_ack[w] = ack; p_gp[w] = 0; p_glitch[w] = 0;
    endtask

    task automatic reset_mid(input bit during_pulse);
        int s;
        s = cyc + 1;
        start = 1'b1;
        expect_ev(0, s, int'(tb_mask(0)), 0);
        goto(s);
        start = 1'b0;
        if (during_pulse) begin
            spawn_ack = 1'b1;
            expect_ev(1, s + 1, 1, 0);
            goto(s + 1);
            spawn_ack = 1'b0;
        end
        @(negedge clk25);
        #1;
        global_reset = 1'b1;
        #1;
        check_all_zero(during_pulse ? "rst_in_pulse" : "rst_in_spawn");
        goto(cyc + 2);
        global_reset = 1'b0;
        enemy_alive  = {EC{1'b0}};
        goto(cyc + 1);
        check_all_zero("rst_release");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        @(posedge clk25);
        #1;
        goto(3);
        check_all_zero("in_reset");
        global_reset = 1'b0;
        goto(cyc + 1);
        check_all_zero("after_reset");
        spawn_ack = 1'b1;
        goto(cyc + 1);
        spawn_ack = 1'b0;
        goto(cyc + 2);

        // Fly cleared on 5th ACTIVE cycle; spider times out leaving slot 18;
        // mosquito cleared, DRAIN waits for slot 18.
        set_wave(0, 0, 4, 0, 0, 0, 0);
        set_wave(1, 1, 2, 18, 0, 0, 1);
        set_wave(2, 0, 2, 21, 0, 0, 0);
        p_drain = 3;
        run_stage();

        // Restart from DONE: 20-cycle pause in a timeout, then clear and
        // timeout on the same cycle.
        set_wave(0, 1, 0, 5, 3, 20, 2);
        set_wave(1, 0, ACT_LEN - 1, 17, 0, 0, 0);
        set_wave(2, 1, 5, 22, 0, 0, 1);
        p_drain = 0;
        run_stage();

        for (int i = 0; i < 6; i++) begin
            rand_plan();
            run_stage();
        end

        reset_mid(1'b0);
        reset_mid(1'b1);
        rand_plan();
        run_stage();

        goto(cyc + 10);
        chk("expected_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_sequencer.md
# wave_sequencer

Stage-level scheduler that sequences the three enemy waves (fly, spider, mosquito) for one stage. It decides when each wave is released: after the previous wave is cleared plus an inter-wave gap, or after a per-wave timeout. It releases each wave to the enemy controller through a request/acknowledge handshake. It sits between the game-state FSM, which supplies `start` and `pause`, and the enemy controller, which consumes the spawn mask and the group reset pulses and returns per-enemy alive flags.

## Interface
- `ENEMY_COUNT`, 23, number of enemy slots.
- `TICK_DIV`, 25_000_000, clk25 cycles per one-second tick.
- `WAVE_TIMEOUT_S`, 10, seconds a wave may stay active before the next wave is forced; range 1..255.
- `GAP_S`, 2, seconds between a cleared wave and the next spawn; range 1..255.

- `clk25`  in  1  system clock.
- `global_reset`  in  1  reset; asynchronous, active-high.
- `start`  in  1  one-cycle request to begin the stage; honoured only in IDLE or DONE.
- `pause`  in  1  level; freezes the tick prescaler and the seconds counter.
- `enemy_alive`  in  ENEMY_COUNT  per-slot alive flags from the enemy controller.
- `spawn_ack`  in  1  enemy controller accepts the current spawn request.
- `spawn_req`  out  1  spawn request; held until acknowledged.
- `spawn_mask`  out  ENEMY_COUNT  slots to set alive; valid while `spawn_req` is high, zero otherwise.
- `reset_fly`, `reset_spider`, `reset_mosquito`  out  1 each  one-cycle group reset pulses.
- `wave_idx`  out  2  current wave: 0 = fly, 1 = spider, 2 = mosquito.
- `busy`  out  1  high in every state except IDLE and DONE.
- `stage_clear`  out  1  high while in DONE.

## Operation
- Wave masks:
  - wave 0 = bits 0..16
  - wave 1 = bits 17..20
  - wave 2 = bits 21..22
- States: IDLE, SPAWN, SETTLE, ACTIVE, GAP, DRAIN, DONE.
- IDLE / DONE:
  - On `start`, set `wave_idx`=0 and go to SPAWN.
  - Any other input is ignored.
- SPAWN:
  - `spawn_req`=1 and `spawn_mask`=mask(`wave_idx`).
  - On `spawn_ack`, drop `spawn_req`, pulse the matching `reset_*`, and go to SETTLE.
  - `pause` does not block the handshake.
- SETTLE: a fixed 2-cycle wait so that `enemy_alive` reflects the spawn; then go to ACTIVE.
- ACTIVE:
  - Cleared = (`enemy_alive` & mask(`wave_idx`)) == 0.
  - If cleared and `wave_idx` < 2, go to GAP.
  - If cleared and `wave_idx` == 2, go to DRAIN.
  - Else if seconds == `WAVE_TIMEOUT_S`: if `wave_idx` < 2, increment it and go to SPAWN; otherwise go to DRAIN.
  - If cleared and the timeout fire in the same cycle, cleared wins.
- GAP: when seconds == `GAP_S`, increment `wave_idx` and go to SPAWN.
- DRAIN: when `enemy_alive` == 0, go to DONE. Survivors from timed-out waves block completion.
- Counters:
  - The prescaler counts 0..`TICK_DIV`-1 and emits a tick on `TICK_DIV`-1.
  - The 8-bit seconds counter increments on each tick.
  - Both counters clear on entry to ACTIVE and to GAP.
  - Both hold while `pause`=1.
- Ignored inputs: `spawn_ack` with `spawn_req` low; `start` while `busy`.

## Timing
- Reset values:
  - state IDLE
  - `spawn_req`=0, `spawn_mask`=0
  - all `reset_*`=0
  - `wave_idx`=0, `busy`=0, `stage_clear`=0
  - both counters 0
- Reset asserted mid-operation returns to IDLE immediately. No partial pulse is allowed to survive.
- Latencies:
  - `start` at cycle n gives `spawn_req`=1 at cycle n+1.
  - `spawn_ack` high at cycle m (with `spawn_req` high) gives `spawn_req`=0 and `reset_*`=1 at m+1, and `reset_*`=0 at m+2.
  - ACTIVE is entered at m+3.
- An unpaused ACTIVE timeout takes exactly `WAVE_TIMEOUT_S`·`TICK_DIV` cycles from ACTIVE entry to the state change. GAP is likewise `GAP_S`·`TICK_DIV` cycles.
- All outputs are registered; no combinational path runs from input to output.

## Structure
- Package `wave_pkg`:
  - state enum
  - the three wave mask constants
  - wave index localparams (`WAVE_FLY`, `WAVE_SPIDER`, `WAVE_MOSQUITO`)
- Sub-module `tick_prescaler`:
  - parameter `TICK_DIV`
  - inputs `clk25`, `global_reset`, `clear`, `hold`
  - output `tick`
- The seconds counter and the FSM stay in `wave_sequencer`.

## Test plan
Bench parameters: `TICK_DIV`=4, `WAVE_TIMEOUT_S`=3, `GAP_S`=1.
- Reset, then `start`: `spawn_req`=1 next cycle with `spawn_mask`=0x01FFFF. Ack it: `reset_fly` pulses for exactly one cycle and `wave_idx`=0.
- In wave 0, drive `enemy_alive`=0 on the 5th ACTIVE cycle: GAP lasts 4 cycles, then `spawn_req` appears with `spawn_mask`=0x1E0000 and `wave_idx`=1.
- Hold the wave 1 bits alive: the timeout occurs exactly 12 cycles after ACTIVE entry, then `spawn_mask`=0x600000 and `wave_idx`=2.
- Assert `pause` for 20 cycles during ACTIVE: the timeout is delayed by exactly 20 cycles.
- Clear wave 2 while bit 18 is still alive: the block stays in DRAIN. Clearing bit 18 gives `stage_clear`=1 the next cycle. A subsequent `start` restarts at wave 0.
- Assert `global_reset` during SPAWN with `spawn_req` high: all outputs read 0 immediately. Clear and timeout in the same cycle: the block goes to GAP.
